// File: rtl/fwd_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_pkg
// Description : Shared types for the forwarding / load-use hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_pkg;

  // Tracked register addresses are held at this width; the unit's RA_W must not exceed it.
  localparam int RA_W_MAX   = 8;
  localparam int FWD_SRC_RF = 0;

  typedef logic [RA_W_MAX-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    logic      regwrite;
    logic      is_load;
    logic      is_store;
  } entry_t;

  function automatic logic writer(input entry_t e, input reg_addr_t r);
    return e.valid & e.regwrite & (e.rd != ZERO_REG) & (e.rd == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_if
// Description : Decode-side bundle between the pipeline and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_if #(
  parameter int RA_W  = 4,
  parameter int DEPTH = 3
);
  localparam int FSEL_W = $clog2(DEPTH);

  logic              freeze;
  logic              flush;
  logic              id_valid;
  logic [RA_W-1:0]   id_rs;
  logic [RA_W-1:0]   id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [RA_W-1:0]   id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              id_is_store;
  logic              stall;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic              fwd_m;

  modport master (
    output freeze, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_rd, id_regwrite, id_is_load, id_is_store,
    input  stall, fwd_a, fwd_b, fwd_m
  );

  modport slave (
    input  freeze, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_rd, id_regwrite, id_is_load, id_is_store,
    output stall, fwd_a, fwd_b, fwd_m
  );
endinterface
`default_nettype wire

// File: rtl/fwd_src_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_src_select
// Description : Picks the youngest in-flight stage (1..DEPTH-1) writing i_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_select
  import fwd_hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int FSEL_W = 2
) (
  input  entry_t [DEPTH-1:0] i_entries,
  input  logic               i_en,
  input  reg_addr_t          i_reg,
  output logic [FSEL_W-1:0]  o_sel
);

  // Walk oldest to youngest so the smallest matching stage is the last assignment.
  always_comb begin
    o_sel = FSEL_W'(FWD_SRC_RF);
    if (i_en) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (writer(i_entries[k], i_reg)) begin
          o_sel = FSEL_W'(k);
        end
      end
    end
  end

  logic w_unused;
  assign w_unused = ^i_entries;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand/store-data forwarding and load-use stall beside decode/EX.
//               Define LOAD_STORE_FWD_EN to forward load data into a following store.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int RA_W  = 4,
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  fwd_hazard_if.slave bus
);

  localparam int     FSEL_W   = $clog2(DEPTH);
  localparam entry_t C_BUBBLE = '0;

  entry_t [DEPTH-1:0] r_entry;
  entry_t             w_idEntry;
  reg_addr_t          w_idRs;
  reg_addr_t          w_idRt;
  logic               w_rsHit;
  logic               w_rtHit;
  logic               w_exempt;
  logic               w_stall;
  logic               w_fwdM;
  logic [FSEL_W-1:0]  w_fwdA;
  logic [FSEL_W-1:0]  w_fwdB;

  assign w_idRs = reg_addr_t'(bus.id_rs);
  assign w_idRt = reg_addr_t'(bus.id_rt);

  always_comb begin
    w_idEntry          = C_BUBBLE;
    w_idEntry.valid    = 1'b1;
    w_idEntry.rs       = w_idRs;
    w_idEntry.rt       = w_idRt;
    w_idEntry.rd       = reg_addr_t'(bus.id_rd);
    w_idEntry.regwrite = bus.id_regwrite;
    w_idEntry.is_load  = bus.id_is_load;
    w_idEntry.is_store = bus.id_is_store;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
    end else if (!bus.freeze) begin
      r_entry[0] <= (bus.flush || w_stall || !bus.id_valid) ? C_BUBBLE : w_idEntry;
      for (int k = 1; k < DEPTH; k++) begin
        r_entry[k] <= r_entry[k-1];
      end
    end
  end

  assign w_rsHit = bus.id_uses_rs & (w_idRs == r_entry[0].rd);
  assign w_rtHit = bus.id_uses_rt & (w_idRt == r_entry[0].rd);

`ifdef LOAD_STORE_FWD_EN
  // Store data can be picked up from WB while the store sits in MEM, so no bubble is needed.
  assign w_exempt = bus.id_is_store & ~w_rsHit;
  assign w_fwdM   = r_entry[1].valid & r_entry[1].is_store & writer(r_entry[2], r_entry[1].rt);
`else
  assign w_exempt = 1'b0;
  assign w_fwdM   = 1'b0;
`endif

  assign w_stall = bus.id_valid & ~bus.flush & r_entry[0].valid & r_entry[0].is_load &
                   (r_entry[0].rd != ZERO_REG) & (w_rsHit | (w_rtHit & ~w_exempt));

  fwd_src_select #(.DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_selA (
    .i_entries (r_entry),
    .i_en      (r_entry[0].valid),
    .i_reg     (r_entry[0].rs),
    .o_sel     (w_fwdA)
  );

  fwd_src_select #(.DEPTH(DEPTH), .FSEL_W(FSEL_W)) u_selB (
    .i_entries (r_entry),
    .i_en      (r_entry[0].valid),
    .i_reg     (r_entry[0].rt),
    .o_sel     (w_fwdB)
  );

  assign bus.stall = w_stall;
  assign bus.fwd_a = w_fwdA;
  assign bus.fwd_b = w_fwdB;
  assign bus.fwd_m = w_fwdM;

endmodule
`default_nettype wire
